// File: rtl/adc_capture_pkg.sv
// Shared definitions for adc_serial_capture: FSM state encoding and the
// saturating offset-removal / scaling helper.
package adc_capture_pkg;

   localparam int unsigned StateW = 3;

   typedef enum logic [StateW-1:0] {
      StIdle,
      StTrack,
      StZeros,
      StRead,
      StHold
   } state_e;

   // Subtract offset from a raw sample, then clamp to [0, 2^out_bits-1]
   // after dropping bit_offset LSBs. Inputs are zero-extended to 32 bits.
   function automatic logic [31:0] sat_scale(input logic [31:0]  raw,
                                             input logic [31:0]  offset,
                                             input int unsigned  out_bits,
                                             input int unsigned  bit_offset);
      logic signed [32:0] diff;
      logic signed [32:0] limit;
      logic [31:0]        ones;
      diff  = $signed({1'b0, raw}) - $signed({1'b0, offset});
      limit = 33'sd1 <<< (out_bits + bit_offset);
      ones  = '1;
      if (diff[32]) begin
         return '0;
      end
      if (diff >= limit) begin
         return ones >> (32 - out_bits);
      end
      return 32'(diff >> bit_offset);
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK timing for adc_serial_capture: half-period counter, toggle strobe,
// sample strobe (the toggle that drives SCLK 1->0) and completed-period count.
// Held cleared while en_i is low, so SCLK always starts low when enabled.
module adc_sclk_gen #(
   parameter int unsigned SCLK_HALF = 1,
   parameter int unsigned PERIOD_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en_i,
   input  logic                clr_i,
   output logic                toggle_o,
   output logic                sample_o,
   output logic [PERIOD_W-1:0] periods_o
);

   localparam int unsigned HalfW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [HalfW-1:0]    half_q, half_d;
   logic                level_q, level_d;
   logic [PERIOD_W-1:0] per_q, per_d;

   assign toggle_o  = en_i && (half_q == HalfW'(SCLK_HALF - 1));
   assign sample_o  = toggle_o && level_q;
   assign periods_o = per_q;

   // Next-state for the half-period counter, SCLK level and period count
   always_comb begin
      half_d  = half_q;
      level_d = level_q;
      per_d   = per_q;
      if (!en_i) begin
         half_d  = '0;
         level_d = 1'b0;
         per_d   = '0;
      end else begin
         if (toggle_o) begin
            half_d  = '0;
            level_d = ~level_q;
         end else begin
            half_d = half_q + 1'b1;
         end
         if (clr_i) begin
            per_d = '0;
         end else if (sample_o) begin
            per_d = per_q + 1'b1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         half_q  <= '0;
         level_q <= 1'b0;
         per_q   <= '0;
      end else begin
         half_q  <= half_d;
         level_q <= level_d;
         per_q   <= per_d;
      end
   end

endmodule

// File: rtl/adc_serial_capture.sv
// Serial-ADC pixel capture engine: tracks, clocks out a zero-prefixed
// MSB-first sample, removes offset, saturates and hands the pixel downstream.
// Build option: define ADC_PIX_INVERT_EN to output the bitwise inverse of
// the scaled code (dark-is-high sensors).
module adc_serial_capture
   import adc_capture_pkg::*;
#(
   parameter int unsigned ADC_BITS   = 12,
   parameter int unsigned ZERO_CLKS  = 3,
   parameter int unsigned OUT_BITS   = 8,
   parameter int unsigned BIT_OFFSET = 1,
   parameter int unsigned SCLK_HALF  = 1,
   parameter int unsigned TRACK_BITS = 8,
   parameter int unsigned IDX_BITS   = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture_start,
   input  logic [TRACK_BITS-1:0] track_counts,
   input  logic [ADC_BITS-1:0]   val_offset,
   input  logic                  line_start,
   input  logic                  sdata,
   output logic                  sclk,
   output logic                  cs_n,
   output logic                  capture_done,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [OUT_BITS-1:0]   pix_data,
   output logic [IDX_BITS-1:0]   pix_index,
   output logic                  overrun
);

   localparam int unsigned MaxPer = (ZERO_CLKS > ADC_BITS) ? ZERO_CLKS : ADC_BITS;
   localparam int unsigned PerW   = $clog2(MaxPer + 1);

   if (OUT_BITS + BIT_OFFSET > ADC_BITS) begin : g_bad_width
      $error("OUT_BITS + BIT_OFFSET must not exceed ADC_BITS");
   end
   if (SCLK_HALF < 1) begin : g_bad_half
      $error("SCLK_HALF must be at least 1");
   end

   state_e                state_q, state_d;
   logic                  req_q;
   logic                  pend_q, pend_d;
   logic                  ovr_q, ovr_d;
   logic                  line_flag_q, line_flag_d;
   logic [TRACK_BITS-1:0] track_cnt_q, track_cnt_d;
   logic [ADC_BITS-2:0]   shift_q, shift_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic                  done_q, done_d;
   logic                  valid_q, valid_d;
   logic [OUT_BITS-1:0]   data_q, data_d;
   logic [IDX_BITS-1:0]   index_q, index_d;

   logic                  gen_en, gen_clr, gen_toggle, gen_sample;
   logic [PerW-1:0]       gen_periods;
   logic                  consume;
   logic [ADC_BITS-1:0]   raw;
   logic [OUT_BITS-1:0]   code, pix_code;
   logic [TRACK_BITS-1:0] track_load;

   assign gen_en     = (state_q == StZeros) || (state_q == StRead);
   // Current sdata completes the word on the final sample edge
   assign raw        = {shift_q, sdata};
   assign code       = OUT_BITS'(sat_scale(32'(raw), 32'(val_offset), OUT_BITS, BIT_OFFSET));
   assign track_load = (track_counts == '0) ? '0 : track_counts - 1'b1;

`ifdef ADC_PIX_INVERT_EN
   assign pix_code = ~code;
`else
   assign pix_code = code;
`endif

   adc_sclk_gen #(
      .SCLK_HALF (SCLK_HALF),
      .PERIOD_W  (PerW)
   ) u_sclk_gen (
      .clk       (clk),
      .reset     (reset),
      .en_i      (gen_en),
      .clr_i     (gen_clr),
      .toggle_o  (gen_toggle),
      .sample_o  (gen_sample),
      .periods_o (gen_periods)
   );

   // FSM next-state, conversion datapath and request bookkeeping
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      ovr_d       = ovr_q;
      line_flag_d = line_flag_q;
      track_cnt_d = track_cnt_q;
      shift_d     = shift_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      done_d      = 1'b0;
      valid_d     = valid_q;
      data_d      = data_q;
      index_d     = index_q;
      gen_clr     = 1'b0;
      consume     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_q || pend_q) begin
               state_d     = StTrack;
               track_cnt_d = track_load;
               consume     = 1'b1;
            end
         end
         StTrack: begin
            if (track_cnt_q == '0) begin
               state_d = StZeros;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               track_cnt_d = track_cnt_q - 1'b1;
            end
         end
         StZeros: begin
            if (gen_toggle) begin
               sclk_d = ~sclk_q;
            end
            if (gen_sample && (gen_periods == PerW'(ZERO_CLKS - 1))) begin
               state_d = StRead;
               gen_clr = 1'b1;
            end
         end
         StRead: begin
            if (gen_toggle) begin
               sclk_d = ~sclk_q;
            end
            if (gen_sample) begin
               shift_d = raw[ADC_BITS-2:0];
               if (gen_periods == PerW'(ADC_BITS - 1)) begin
                  state_d     = StHold;
                  sclk_d      = 1'b1;
                  cs_n_d      = 1'b1;
                  valid_d     = 1'b1;
                  data_d      = pix_code;
                  index_d     = line_flag_q ? '0 :
                                (index_q == {IDX_BITS{1'b1}}) ? index_q : index_q + 1'b1;
                  line_flag_d = 1'b0;
               end
            end
         end
         StHold: begin
            if (pix_ready) begin
               valid_d = 1'b0;
               if (pend_q) begin
                  state_d     = StTrack;
                  track_cnt_d = track_load;
                  consume     = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (line_start) begin
         line_flag_d = 1'b1;
         ovr_d       = 1'b0;
      end

      if (consume) begin
         pend_d = 1'b0;
      end
      // A request arriving as the pending one is consumed takes its place
      if (req_q && (state_q != StIdle)) begin
         if (pend_q && !consume) begin
            ovr_d = 1'b1;
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         req_q       <= 1'b0;
         pend_q      <= 1'b0;
         ovr_q       <= 1'b0;
         // First pixel after reset starts a fresh line
         line_flag_q <= 1'b1;
         track_cnt_q <= '0;
         shift_q     <= '0;
         sclk_q      <= 1'b1;
         cs_n_q      <= 1'b1;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         index_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= capture_start;
         pend_q      <= pend_d;
         ovr_q       <= ovr_d;
         line_flag_q <= line_flag_d;
         track_cnt_q <= track_cnt_d;
         shift_q     <= shift_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         index_q     <= index_d;
      end
   end

   assign sclk         = sclk_q;
   assign cs_n         = cs_n_q;
   assign capture_done = done_q;
   assign pix_valid    = valid_q;
   assign pix_data     = data_q;
   assign pix_index    = index_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Self-checking bench for adc_serial_capture: ADC serial model, scoreboard of
// expected pixels, and a handshake monitor that pops and compares.
module tb_adc_serial_capture;

`ifdef ADC_PIX_INVERT_EN
   localparam bit Inv = 1'b1;
`else
   localparam bit Inv = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        capture_start = 1'b0;
   logic [7:0]  track_counts = 8'd14;
   logic [11:0] val_offset = 12'h000;
   logic        line_start = 1'b0;
   logic        sdata = 1'b0;
   logic        sclk;
   logic        cs_n;
   logic        capture_done;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [7:0]  pix_data;
   logic [6:0]  pix_index;
   logic        overrun;

   adc_serial_capture dut (
      .clk          (clk),
      .reset        (reset),
      .capture_start(capture_start),
      .track_counts (track_counts),
      .val_offset   (val_offset),
      .line_start   (line_start),
      .sdata        (sdata),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .capture_done (capture_done),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_data     (pix_data),
      .pix_index    (pix_index),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [6:0] idx;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          acc_cnt = 0;
   int          cyc = 0;
   int          fall_cnt = 0;
   int          adc_cnt = 0;
   int          nxt_idx = 0;
   logic [11:0] adc_raw = 12'h000;
   logic        cs_prev = 1'b1;
   logic        sclk_prev = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC model: first leading zero on CS fall, next bit on each SCLK fall
   always @(posedge clk) begin
      #1;
      if (!cs_n && sclk_prev && !sclk) fall_cnt++;
      if (cs_prev && !cs_n) adc_cnt = 0;
      else if (!cs_n && sclk_prev && !sclk) adc_cnt++;
      if (!cs_n && adc_cnt >= 3 && adc_cnt < 15) sdata = adc_raw[14-adc_cnt];
      else sdata = 1'b0;
      cs_prev   = cs_n;
      sclk_prev = sclk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every accepted pixel is compared with the oldest expectation
   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && pix_valid && pix_ready) begin
         acc_cnt++;
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pixel: got data 0x%0h index %0d, expected none",
                     pix_data, pix_index);
         end else begin
            e = sb.pop_front();
            check("pix_data", 32'(pix_data), 32'(e.data));
            check("pix_index", 32'(pix_index), 32'(e.idx));
         end
      end
   end

   function automatic logic [7:0] px(input logic [7:0] c);
      return Inv ? ~c : c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [7:0] c);
      exp_t e;
      e.data  = px(c);
      e.idx   = 7'(nxt_idx);
      sb.push_back(e);
      nxt_idx = (nxt_idx == 127) ? 127 : nxt_idx + 1;
   endtask

   task automatic pulse_start();
      capture_start = 1'b1;
      tick();
      capture_start = 1'b0;
   endtask

   task automatic pulse_line();
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      nxt_idx    = 0;
   endtask

   task automatic wait_done(input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (capture_done) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int bound, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (pix_valid) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound; i++) begin
         tick();
         if (sb.size() == 0 && !pix_valid) break;
      end
      check("drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic convert(input logic [11:0] r, input logic [11:0] off, input logic [7:0] c);
      adc_raw    = r;
      val_offset = off;
      push_exp(c);
      pulse_start();
      drain(200);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
      $fatal(1, "bench time limit");
   end

   initial begin : main
      int t0;
      int at;
      int acc0;
      int v;
      logic hold_ok;
      logic [7:0] held_data;
      logic [6:0] held_idx;

      tick();
      tick();
      check("rst_sclk", 32'(sclk), 32'd1);
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_done", 32'(capture_done), 32'd0);
      check("rst_valid", 32'(pix_valid), 32'd0);
      check("rst_data", 32'(pix_data), 32'd0);
      check("rst_index", 32'(pix_index), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b0;
      tick();

      // Basic conversion with latency and SCLK edge count
      track_counts = 8'd14;
      adc_raw      = 12'h134;
      val_offset   = 12'h034;
      fall_cnt     = 0;
      push_exp(8'h80);
      t0 = cyc + 1;
      pulse_start();
      wait_done(100, at);
      check("done_at_t15", 32'(at), 32'(t0 + 15));
      tick();
      check("done_one_cycle", 32'(capture_done), 32'd0);
      wait_valid(100, at);
      check("valid_at_t45", 32'(at), 32'(t0 + 45));
      drain(100);
      check("sclk_falls", 32'(fall_cnt), 32'd15);

      // Scaling corners
      convert(12'h010, 12'h020, 8'h00);
      convert(12'h3FF, 12'h000, 8'hFF);
      convert(12'h1FF, 12'h000, 8'hFF);
      convert(12'h200, 12'h000, 8'hFF);
      convert(12'h0FE, 12'h000, 8'h7F);
      convert(12'h022, 12'h020, 8'h01);
      convert(12'h021, 12'h020, 8'h00);

      // track_counts of zero behaves as one
      track_counts = 8'd0;
      adc_raw      = 12'h0A5;
      val_offset   = 12'h000;
      push_exp(8'h52);
      t0 = cyc + 1;
      pulse_start();
      wait_valid(100, at);
      check("track0_latency", 32'(at), 32'(t0 + 32));
      drain(100);

      // Backpressure
      track_counts = 8'd14;
      pix_ready    = 1'b0;
      adc_raw      = 12'h0FE;
      val_offset   = 12'h000;
      push_exp(8'h7F);
      t0 = cyc + 1;
      pulse_start();
      wait_valid(100, at);
      check("bp_valid_at", 32'(at), 32'(t0 + 45));
      held_data = pix_data;
      held_idx  = pix_index;
      hold_ok   = 1'b1;
      acc0      = acc_cnt;
      repeat (20) begin
         tick();
         if (!pix_valid || pix_data !== held_data || pix_index !== held_idx || !sclk || !cs_n)
            hold_ok = 1'b0;
      end
      check("bp_hold", 32'(hold_ok), 32'd1);
      check("bp_no_accept", 32'(acc_cnt), 32'(acc0));
      pix_ready = 1'b1;
      drain(50);
      check("bp_accept_once", 32'(acc_cnt), 32'(acc0 + 1));

      // Pending request and overrun
      acc0       = acc_cnt;
      adc_raw    = 12'h134;
      val_offset = 12'h034;
      push_exp(8'h80);
      t0 = cyc + 1;
      pulse_start();
      wait_done(100, at);
      repeat (12) tick();
      push_exp(8'h52);
      pulse_start();
      repeat (2) tick();
      check("pend_no_overrun", 32'(overrun), 32'd0);
      pulse_start();
      repeat (2) tick();
      check("overrun_set", 32'(overrun), 32'd1);
      wait_valid(100, v);
      check("pend_first_valid", 32'(v), 32'(t0 + 45));
      adc_raw    = 12'h0A5;
      val_offset = 12'h000;
      wait_done(100, at);
      check("pend_track_after_hs", 32'(at), 32'(v + 15));
      drain(200);
      repeat (60) tick();
      check("pend_two_pixels", 32'(acc_cnt), 32'(acc0 + 2));
      check("overrun_sticky", 32'(overrun), 32'd1);
      pulse_line();
      check("overrun_cleared", 32'(overrun), 32'd0);

      // Index saturation across a long line
      track_counts = 8'd1;
      pulse_line();
      for (int i = 0; i < 130; i++) convert(12'h0A5, 12'h000, 8'h52);
      pulse_line();
      convert(12'h134, 12'h034, 8'h80);

      // Reset in the middle of READ
      track_counts = 8'd14;
      adc_raw      = 12'h134;
      val_offset   = 12'h034;
      pulse_start();
      wait_done(100, at);
      repeat (16) tick();
      check("pre_rst_cs_low", 32'(cs_n), 32'd0);
      #3;
      reset = 1'b1;
      #1;
      check("midrst_sclk", 32'(sclk), 32'd1);
      check("midrst_cs_n", 32'(cs_n), 32'd1);
      check("midrst_valid", 32'(pix_valid), 32'd0);
      tick();
      tick();
      reset   = 1'b0;
      nxt_idx = 0;
      tick();
      convert(12'h022, 12'h020, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
